// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks: scan FSM encoding,
// blanking constants and the active-low hex glyph patterns ({g,f,e,d,c,b,a}).
package seg7_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit hex to active-low 7-segment lookup, shared by the
// display blocks.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_seg = SEG_OFF;
    case (i_hex)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment scanner: clk_1K edges advance the
// digit, a blank gap separates digits, and inputs are latched once per frame.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk_100M,
  input  logic                    rst,
  input  logic                    clk_1K,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES);

  logic r_s0, r_s1, r_s2, r_scan_tick;
  state_t r_state, w_state_nxt;
  logic [IDX_W-1:0] r_index, w_index_nxt;
  logic [CNT_W-1:0] r_blank_cnt, w_blank_cnt_nxt;
  logic [4*NUM_DIGITS-1:0] r_sh_data, w_sh_data_nxt;
  logic [NUM_DIGITS-1:0] r_sh_dp, w_sh_dp_nxt, r_sh_en, w_sh_en_nxt;
  logic w_latch, w_frame_nxt;
  logic [NUM_DIGITS-1:0] r_an, w_an_nxt;
  logic [6:0] r_seg, w_seg_nxt, w_seg_dec;
  logic r_dp, w_dp_nxt, r_frame_done;

  // NOTE: clk_1K is asynchronous data; two flops settle it before the edge flop looks at it.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      r_s0        <= 1'b0;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_scan_tick <= 1'b0;
    end else begin
      r_s0        <= clk_1K;
      r_s1        <= r_s0;
      r_s2        <= r_s1;
      r_scan_tick <= r_s1 & ~r_s2;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_index_nxt     = r_index;
    w_blank_cnt_nxt = r_blank_cnt;
    w_frame_nxt     = 1'b0;
    w_latch         = 1'b0;
    case (r_state)
      ST_BLANK: begin
        w_blank_cnt_nxt = r_blank_cnt - CNT_W'(1);
        if (r_blank_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_DRIVE;
          w_latch     = (r_index == '0);
        end
      end
      ST_DRIVE: begin
        if (r_scan_tick) begin
          w_index_nxt     = (r_index == IDX_LAST) ? '0 : r_index + IDX_W'(1);
          w_frame_nxt     = (r_index == IDX_LAST);
          w_blank_cnt_nxt = CNT_LOAD;
          w_state_nxt     = ST_BLANK;
        end
      end
      default: w_state_nxt = ST_BLANK;
    endcase
  end

  // Outputs are computed from next-state values so the registers change on the entering edge.
  assign w_sh_data_nxt = w_latch ? data     : r_sh_data;
  assign w_sh_dp_nxt   = w_latch ? dp_in    : r_sh_dp;
  assign w_sh_en_nxt   = w_latch ? digit_en : r_sh_en;

  seg7_hex_decode u_decode (
    .i_hex (w_sh_data_nxt[{w_index_nxt, 2'b00} +: 4]),
    .o_seg (w_seg_dec)
  );

  always_comb begin
    w_an_nxt  = AN_OFF[NUM_DIGITS-1:0];
    w_seg_nxt = SEG_OFF;
    w_dp_nxt  = 1'b1;
    if (w_state_nxt == ST_DRIVE && w_sh_en_nxt[w_index_nxt]) begin
      w_an_nxt[w_index_nxt] = 1'b0;
      w_seg_nxt             = w_seg_dec;
      w_dp_nxt              = ~w_sh_dp_nxt[w_index_nxt];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      r_state      <= ST_BLANK;
      r_index      <= '0;
      r_blank_cnt  <= CNT_LOAD;
      // NOTE: the shadow registers are reset too, so the first frame never shows stale contents.
      r_sh_data    <= '0;
      r_sh_dp      <= '0;
      r_sh_en      <= '0;
      r_an         <= AN_OFF[NUM_DIGITS-1:0];
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_index      <= w_index_nxt;
      r_blank_cnt  <= w_blank_cnt_nxt;
      r_sh_data    <= w_sh_data_nxt;
      r_sh_dp      <= w_sh_dp_nxt;
      r_sh_en      <= w_sh_en_nxt;
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_done <= w_frame_nxt;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: a per-cycle behavioural scoreboard plus
// directed scan, blanking, anti-tear, mask, glitch and reset vectors.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_1K = 1'b0;
  logic [31:0] data = 32'h89ABCDEF;
  logic [7:0]  dp_in = 8'h00;
  logic [7:0]  digit_en = 8'hFF;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_seen  = 0;
  bit cmp_on   = 1'b0;

  // Glyph table written straight from the display's character set.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  // Hand-computed views of 32'h89ABCDEF, digit 0 first.
  logic [7:0] an_walk  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] seg_walk [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
  // digit_en=0F, dp_in=FF, data=32'h76543210.
  logic [7:0] an_mask  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [6:0] seg_mask [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic       dp_mask  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  seg7_scan #(.NUM_DIGITS(8), .BLANK_CYCLES(16)) dut (
    .clk_100M   (clk),
    .rst        (rst),
    .clk_1K     (clk_1K),
    .data       (data),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a rise of clk_1K seen three samples ago, while the display is
  // showing a digit, starts a 16-cycle dark gap and moves to the next digit; the frame's
  // inputs are captured when digit 0 comes out of its gap.
  int         m_blank = 16;
  int         m_digit = 0;
  bit         m_frame = 1'b0;
  bit [3:0]   m_hist  = '0;
  logic [31:0] m_data = '0;
  logic [7:0]  m_dp   = '0;
  logic [7:0]  m_en   = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_blank = 16; m_digit = 0; m_frame = 1'b0; m_hist = '0;
      m_data = '0; m_dp = '0; m_en = '0;
    end else begin
      bit rise_seen;
      rise_seen = m_hist[2] && !m_hist[3];
      m_hist    = {m_hist[2:0], clk_1K};
      m_frame   = 1'b0;
      if (m_blank > 0) begin
        m_blank--;
        if (m_blank == 0 && m_digit == 0) begin
          m_data = data; m_dp = dp_in; m_en = digit_en;
        end
      end else if (rise_seen) begin
        m_frame = (m_digit == 7);
        m_digit = (m_digit + 1) % 8;
        m_blank = 16;
      end
    end
  end

  initial forever begin
    logic [7:0] ea;
    logic [6:0] es;
    logic       ed;
    @(negedge clk);
    if (!rst && frame_done) fd_seen++;
    if (!rst && cmp_on) begin
      ea = 8'hFF; es = 7'h7F; ed = 1'b1;
      if (m_blank == 0 && m_en[m_digit]) begin
        ea[m_digit] = 1'b0;
        es = seg_tab[m_data[m_digit*4 +: 4]];
        ed = !m_dp[m_digit];
      end
      check("scan_cycle", {15'b0, an, seg, dp, frame_done}, {15'b0, ea, es, ed, m_frame});
    end
  end

  // One clk_1K period of 100 cycles starting with a rise; reports the negedge index of
  // the first dark sample and of the first lit sample after it.
  task automatic k_period(output int lat, output int drv);
    lat = 0; drv = 0;
    clk_1K = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 50) clk_1K = 1'b0;
      if (an == 8'hFF && lat == 0) lat = i;
      if (an != 8'hFF && lat != 0 && drv == 0) drv = i;
    end
  endtask

  task automatic blank_after_reset(output int n);
    n = 0;
    @(negedge clk);
    while (an == 8'hFF && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, drv, n_ff, fd0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_an", {24'b0, an}, 32'hFF);
    check("reset_seg", {25'b0, seg}, 32'h7F);
    check("reset_dp_fd", {30'b0, dp, frame_done}, 32'h2);
    rst = 1'b0;
    cmp_on = 1'b1;
    blank_after_reset(n_ff);
    check("reset_blank_len", n_ff, 16);
    check("reset_first_digit", {17'b0, an, seg}, {17'b0, 8'hFE, 7'h0E});

    // Scan walk over one full frame; wrap back to digit 0 gives exactly one frame_done.
    fd0 = fd_seen;
    for (int p = 1; p <= 8; p++) begin
      k_period(lat, drv);
      if (p == 1) begin
        check("tick_latency", lat, 4);
        check("first_drive_after_rise", drv, 3 + 1 + 16);
      end
      check("walk_an", {24'b0, an}, {24'b0, an_walk[p % 8]});
      check("walk_seg", {25'b0, seg}, {25'b0, seg_walk[p % 8]});
    end
    check("walk_frame_done", fd_seen - fd0, 1);

    // Anti-tear: new data mid-frame only shows from the next frame.
    for (int p = 1; p <= 3; p++) k_period(lat, drv);
    check("tear_digit3_before", {17'b0, an, seg}, {17'b0, 8'hF7, 7'h46});
    data = 32'h0;
    repeat (5) @(negedge clk);
    check("tear_digit3_after", {25'b0, seg}, 32'h46);
    for (int d = 4; d <= 7; d++) begin
      k_period(lat, drv);
      check("tear_old_nibble", {25'b0, seg}, {25'b0, seg_walk[d]});
    end
    for (int d = 0; d <= 7; d++) begin
      k_period(lat, drv);
      check("tear_new_frame", {17'b0, an, seg}, {17'b0, an_walk[d], 7'h40});
    end

    // Masks: upper four digits disabled, all decimal points requested.
    digit_en = 8'h0F;
    dp_in    = 8'hFF;
    data     = 32'h76543210;
    for (int d = 0; d <= 7; d++) begin
      k_period(lat, drv);
      check("mask_digit", {16'b0, an, seg, dp}, {16'b0, an_mask[d], seg_mask[d], dp_mask[d]});
    end

    // Glitchy clk_1K: two one-cycle pulses advance the index by exactly one.
    k_period(lat, drv);
    check("glitch_start", {24'b0, an}, 32'hFE);
    clk_1K = 1'b1; @(negedge clk);
    clk_1K = 1'b0; @(negedge clk);
    clk_1K = 1'b1; @(negedge clk);
    clk_1K = 1'b0;
    repeat (60) @(negedge clk);
    check("glitch_one_step", {16'b0, an, seg, dp}, {16'b0, 8'hFD, 7'h79, 1'b0});
    repeat (100) @(negedge clk);
    check("glitch_no_second", {24'b0, an}, 32'hFD);

    // Asynchronous reset mid-DRIVE blanks the outputs before the next clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_outputs", {15'b0, an, seg, dp, frame_done}, {15'b0, 8'hFF, 7'h7F, 1'b1, 1'b0});
    @(posedge clk);
    #1 rst = 1'b0;
    blank_after_reset(n_ff);
    check("midreset_blank_len", n_ff, 16);
    check("midreset_first_digit", {16'b0, an, seg, dp}, {16'b0, 8'hFE, 7'h40, 1'b0});

    repeat (4) @(negedge clk);
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
